// File: rtl/bundle_fetch_ctrl.sv
// VLIW bundle fetch sequencer: owns the PC, issues one fetch at a time, buffers bundles in out+skid slots.
// Optional perf counters (perf_bundles, perf_stalls) when FETCH_PERF_CNT_EN is defined.
module bundle_fetch_ctrl #(
  parameter int              NFU      = 2,
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  output logic                fetch_req,
  output logic [PC_W-1:0]     fetch_addr,
  input  logic                fetch_rsp_valid,
  input  logic [NFU*32-1:0]   fetch_rsp_data,
  input  logic [NFU-1:0]      fu_stall,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic                bundle_valid,
  output logic [NFU*32-1:0]   bundle_data,
  output logic [PC_W-1:0]     bundle_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_bundles,
  output logic [31:0]         perf_stalls
`endif
);

  localparam int BUNDLE_BYTES = NFU * 4;
  localparam int BUNDLE_W     = NFU * 32;
  localparam int ALIGN        = $clog2(BUNDLE_BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]          r_state;
  logic [PC_W-1:0]     r_pc;
  logic                r_fetch_req;
  logic [PC_W-1:0]     r_fetch_addr;
  logic                r_out_valid;
  logic [BUNDLE_W-1:0] r_out_data;
  logic [PC_W-1:0]     r_out_pc;
  logic                r_skid_valid;
  logic [BUNDLE_W-1:0] r_skid_data;
  logic [PC_W-1:0]     r_skid_pc;

  logic [1:0]          w_state_nxt;
  logic [PC_W-1:0]     w_pc_nxt;
  logic [PC_W-1:0]     w_pc_inc;
  logic [PC_W-1:0]     w_redirect_aligned;
  logic                w_req_active;
  logic                w_consume;
  logic                w_rsp_accept;
  logic                w_new_req;
  logic                w_out_free;
  logic                w_unused_lsb;

  assign w_pc_inc           = r_pc + PC_W'(BUNDLE_BYTES);
  assign w_redirect_aligned = {redirect_pc[PC_W-1:ALIGN], {ALIGN{1'b0}}};
  assign w_unused_lsb       = ^redirect_pc[ALIGN-1:0];

  // Next-state, next-PC and request-launch decode
  always_comb begin
    w_req_active = (r_state == S_FETCH) || (r_state == S_FLUSH);
    w_consume    = r_out_valid & ~(|fu_stall);
    w_out_free   = ~r_out_valid | w_consume;
    w_rsp_accept = (r_state == S_FETCH) & fetch_rsp_valid & ~redirect_valid;
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    if (redirect_valid) begin
      w_pc_nxt = w_redirect_aligned;
      case (r_state)
        S_FETCH, S_FLUSH: begin
          if (fetch_rsp_valid) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_FETCH;
        S_FETCH: begin
          if (w_rsp_accept) begin
            w_pc_nxt = w_pc_inc;
            if (w_out_free) begin
              w_state_nxt = S_FETCH;
            end else begin
              w_state_nxt = S_HOLD;
            end
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
        S_HOLD: begin
          if (w_consume) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
        S_FLUSH: begin
          if (fetch_rsp_valid) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    // A new request starts when entering S_FETCH from a non-requesting state or after a completion.
    w_new_req = (w_state_nxt == S_FETCH) && (!w_req_active || fetch_rsp_valid);
  end

  // FSM, PC and fetch request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_fetch_req  <= 1'b0;
      r_fetch_addr <= RESET_PC;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_fetch_req <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_FLUSH);
      if (w_new_req) begin
        r_fetch_addr <= w_pc_nxt;
      end else begin
        r_fetch_addr <= r_fetch_addr;
      end
    end
  end

  // Out slot and skid buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= {BUNDLE_W{1'b0}};
      r_out_pc     <= {PC_W{1'b0}};
      r_skid_valid <= 1'b0;
      r_skid_data  <= {BUNDLE_W{1'b0}};
      r_skid_pc    <= {PC_W{1'b0}};
    end else if (redirect_valid) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_pc     <= r_skid_pc;
        r_skid_valid <= 1'b0;
      end else if (w_rsp_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= fetch_rsp_data;
        r_out_pc    <= r_pc;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_rsp_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= fetch_rsp_data;
      r_skid_pc    <= r_pc;
    end else begin
      r_skid_valid <= r_skid_valid;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_bundles;
  logic [31:0] r_perf_stalls;

  // Issue and stall counters; redirects do not touch them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_bundles <= 32'd0;
      r_perf_stalls  <= 32'd0;
    end else begin
      if (w_consume) begin
        r_perf_bundles <= r_perf_bundles + 32'd1;
      end else begin
        r_perf_bundles <= r_perf_bundles;
      end
      if (r_out_valid && (|fu_stall)) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end else begin
        r_perf_stalls <= r_perf_stalls;
      end
    end
  end

  assign perf_bundles = r_perf_bundles;
  assign perf_stalls  = r_perf_stalls;
`endif

  assign fetch_req    = r_fetch_req;
  assign fetch_addr   = r_fetch_addr;
  assign bundle_valid = r_out_valid;
  assign bundle_data  = r_out_data;
  assign bundle_pc    = r_out_pc;

endmodule

// File: tb/tb_bundle_fetch_ctrl.sv
// Table-driven bench for bundle_fetch_ctrl plus a PC-wrap sequence on an 8-bit-PC instance.
module tb_bundle_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [63:0] fetch_addr;
  logic        fetch_rsp_valid;
  logic [63:0] fetch_rsp_data;
  logic [1:0]  fu_stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        bundle_valid;
  logic [63:0] bundle_data;
  logic [63:0] bundle_pc;

  logic        w_rst;
  logic        w_fetch_req;
  logic [7:0]  w_fetch_addr;
  logic        w_rsp_valid;
  logic [63:0] w_rsp_data;
  logic [1:0]  w_stall;
  logic        w_redirect;
  logic [7:0]  w_redirect_pc;
  logic        w_bundle_valid;
  logic [63:0] w_bundle_data;
  logic [7:0]  w_bundle_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_b, perf_s, w_perf_b, w_perf_s;
`endif

  int checks = 0;
  int errors = 0;
  int cur_row = 0;

  bundle_fetch_ctrl #(.NFU(2), .PC_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data),
    .fu_stall(fu_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bundle_valid(bundle_valid), .bundle_data(bundle_data), .bundle_pc(bundle_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_bundles(perf_b), .perf_stalls(perf_s)
`endif
  );

  bundle_fetch_ctrl #(.NFU(2), .PC_W(8), .RESET_PC(8'hF8)) dut_wrap (
    .clk(clk), .rst(w_rst), .fetch_req(w_fetch_req), .fetch_addr(w_fetch_addr),
    .fetch_rsp_valid(w_rsp_valid), .fetch_rsp_data(w_rsp_data),
    .fu_stall(w_stall), .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .bundle_valid(w_bundle_valid), .bundle_data(w_bundle_data), .bundle_pc(w_bundle_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_bundles(w_perf_b), .perf_stalls(w_perf_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdr;
    logic [63:0] rpc;
    logic [1:0]  stall;
    logic        rsp;
    logic [63:0] raddr;
    logic        req;
    logic [63:0] fa;
    logic        bv;
    logic [63:0] bpc;
  } vec_t;

  localparam int NV = 29;
  vec_t vt [NV];

  function automatic logic [63:0] mk(input logic [63:0] a);
    return {~a[31:0], a[31:0]};
  endfunction

  function automatic vec_t v(input logic r, input logic rd, input logic [63:0] rp,
                             input logic [1:0] st, input logic rs, input logic [63:0] ra,
                             input logic q, input logic [63:0] f, input logic b,
                             input logic [63:0] p);
    vec_t x;
    x.rst = r; x.rdr = rd; x.rpc = rp; x.stall = st; x.rsp = rs; x.raddr = ra;
    x.req = q; x.fa = f; x.bv = b; x.bpc = p;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d actual=%h expected=%h", name, cur_row, act, exp);
    end
  endtask

  initial begin
    // rst rd  rpc         stall rsp raddr    | req fa         bv  bpc
    vt[0]  = v(1'b1, 1'b0, 64'h0,    2'b00, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0);
    vt[1]  = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b0, 64'h0,    1'b1, 64'h0,    1'b0, 64'h0);
    vt[2]  = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b1, 64'h0,    1'b1, 64'h8,    1'b1, 64'h0);
    vt[3]  = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b1, 64'h8,    1'b1, 64'h10,   1'b1, 64'h8);
    vt[4]  = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b1, 64'h10,   1'b1, 64'h18,   1'b1, 64'h10);
    vt[5]  = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b0, 64'h0,    1'b1, 64'h18,   1'b0, 64'h0);
    vt[6]  = v(1'b1, 1'b0, 64'h0,    2'b00, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0);
    vt[7]  = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b0, 64'h0,    1'b1, 64'h0,    1'b0, 64'h0);
    vt[8]  = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b1, 64'h0,    1'b1, 64'h8,    1'b1, 64'h0);
    vt[9]  = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b1, 64'h8,    1'b1, 64'h10,   1'b1, 64'h8);
    vt[10] = v(1'b0, 1'b0, 64'h0,    2'b01, 1'b0, 64'h0,    1'b1, 64'h10,   1'b1, 64'h8);
    vt[11] = v(1'b0, 1'b0, 64'h0,    2'b01, 1'b1, 64'h10,   1'b0, 64'h10,   1'b1, 64'h8);
    vt[12] = v(1'b0, 1'b0, 64'h0,    2'b01, 1'b0, 64'h0,    1'b0, 64'h10,   1'b1, 64'h8);
    vt[13] = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b0, 64'h0,    1'b1, 64'h18,   1'b1, 64'h10);
    vt[14] = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b0, 64'h0,    1'b1, 64'h18,   1'b0, 64'h0);
    vt[15] = v(1'b0, 1'b1, 64'h1004, 2'b00, 1'b0, 64'h0,    1'b1, 64'h18,   1'b0, 64'h0);
    vt[16] = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b1, 64'h18,   1'b1, 64'h1000, 1'b0, 64'h0);
    vt[17] = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b1, 64'h1000, 1'b1, 64'h1008, 1'b1, 64'h1000);
    vt[18] = v(1'b0, 1'b1, 64'h2000, 2'b00, 1'b1, 64'h1008, 1'b1, 64'h2000, 1'b0, 64'h0);
    vt[19] = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b1, 64'h2000, 1'b1, 64'h2008, 1'b1, 64'h2000);
    vt[20] = v(1'b0, 1'b0, 64'h0,    2'b10, 1'b1, 64'h2008, 1'b0, 64'h2008, 1'b1, 64'h2000);
    vt[21] = v(1'b0, 1'b1, 64'h3007, 2'b10, 1'b0, 64'h0,    1'b1, 64'h3000, 1'b0, 64'h0);
    vt[22] = v(1'b0, 1'b0, 64'h0,    2'b10, 1'b1, 64'h3000, 1'b1, 64'h3008, 1'b1, 64'h3000);
    vt[23] = v(1'b0, 1'b1, 64'h4000, 2'b00, 1'b0, 64'h0,    1'b1, 64'h3008, 1'b0, 64'h0);
    vt[24] = v(1'b0, 1'b1, 64'h5000, 2'b00, 1'b0, 64'h0,    1'b1, 64'h3008, 1'b0, 64'h0);
    vt[25] = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b1, 64'h3008, 1'b1, 64'h5000, 1'b0, 64'h0);
    vt[26] = v(1'b0, 1'b0, 64'h0,    2'b00, 1'b1, 64'h5000, 1'b1, 64'h5008, 1'b1, 64'h5000);
    vt[27] = v(1'b0, 1'b0, 64'h0,    2'b01, 1'b1, 64'h5008, 1'b0, 64'h5008, 1'b1, 64'h5000);
    vt[28] = v(1'b1, 1'b0, 64'h0,    2'b01, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h0);

    w_rst = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = 64'h0; w_stall = 2'b00;
    w_redirect = 1'b0; w_redirect_pc = 8'h0;

    for (int i = 0; i < NV; i++) begin
      cur_row         = i;
      rst             = vt[i].rst;
      redirect_valid  = vt[i].rdr;
      redirect_pc     = vt[i].rpc;
      fu_stall        = vt[i].stall;
      fetch_rsp_valid = vt[i].rsp;
      fetch_rsp_data  = mk(vt[i].raddr);
      @(posedge clk);
      #1;
      chk("fetch_req", {63'h0, fetch_req}, {63'h0, vt[i].req});
      chk("fetch_addr", fetch_addr, vt[i].fa);
      chk("bundle_valid", {63'h0, bundle_valid}, {63'h0, vt[i].bv});
      if (vt[i].bv) begin
        chk("bundle_pc", bundle_pc, vt[i].bpc);
        chk("bundle_data", bundle_data, mk(vt[i].bpc));
      end
    end

    // Reset taken mid-hold: data and pc return to zero
    cur_row = 100;
    chk("rst_bundle_data", bundle_data, 64'h0);
    chk("rst_bundle_pc", bundle_pc, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_bundles", {32'h0, perf_b}, 64'h0);
    chk("rst_perf_stalls", {32'h0, perf_s}, 64'h0);
`endif
    rst = 1'b0; fu_stall = 2'b00;

    // PC wrap on an 8-bit PC starting at 0xF8
    cur_row = 200;
    w_rst = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
        @(posedge clk);
        #1;
        seen = w_fetch_req;
      end
      chk("wrap_req_timeout", {63'h0, seen}, 64'h1);
    end
    chk("wrap_fa0", {56'h0, w_fetch_addr}, 64'hF8);
    w_rsp_valid = 1'b1; w_rsp_data = mk(64'hF8);
    @(posedge clk);
    #1;
    chk("wrap_fa1", {56'h0, w_fetch_addr}, 64'h00);
    chk("wrap_bv1", {63'h0, w_bundle_valid}, 64'h1);
    chk("wrap_bpc1", {56'h0, w_bundle_pc}, 64'hF8);
    chk("wrap_data1", w_bundle_data, mk(64'hF8));
    w_rsp_data = mk(64'h00);
    @(posedge clk);
    #1;
    chk("wrap_fa2", {56'h0, w_fetch_addr}, 64'h08);
    chk("wrap_bpc2", {56'h0, w_bundle_pc}, 64'h00);
    chk("wrap_data2", w_bundle_data, mk(64'h00));
    w_rsp_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
